hazard_control_unit: RTL and testbench
======================================

Name: hazard_control_unit

Overview:
Central stall/flush sequencer for the 5-stage pipeline; the forwarding unit covers ALU-to-ALU hazards, this block covers everything forwarding cannot resolve.
- Detects load-use hazards and inserts one bubble.
- Flushes IF/ID and ID/EX on a taken branch resolved in EX.
- Runs the start/done handshake with the multicycle MUL/DIV unit and freezes the pipeline while that unit is busy.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
REG_ADDR_W, 5, register-index width
MC_TIMEOUT, 64, max cycles in MC_WAIT before mc_error is raised
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
if_id_rs1  in  REG_ADDR_W  rs1 of instruction in ID
if_id_rs2  in  REG_ADDR_W  rs2 of instruction in ID
if_id_rs1_used  in  1  ID instruction reads rs1
if_id_rs2_used  in  1  ID instruction reads rs2
id_ex_mem_read  in  1  EX-stage instruction is a load
id_ex_rd  in  REG_ADDR_W  destination of EX-stage instruction
id_ex_mc_op  in  1  EX-stage instruction is MUL/DIV
ex_branch_taken  in  1  branch/jump in EX resolved taken
mc_done  in  1  multicycle unit result valid (1-cycle pulse)
pc_write  out  1  PC register enable
if_id_write  out  1  IF/ID register enable
id_ex_write  out  1  ID/EX register enable
id_ex_bubble  out  1  force ID/EX control to zero (NOP)
if_id_flush  out  1  clear IF/ID to NOP
ex_mem_bubble  out  1  force EX/MEM control to zero
mc_start  out  1  start pulse to multicycle unit
mc_error  out  1  sticky timeout flag
stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (rst=1 at a clk edge): state=RUN, timeout counter=0, mc_error=0, stall_count=0, mc_started flag=0.
- Decode outputs are combinational from state and inputs. While rst=1 they are forced to: pc_write=1, if_id_write=1, id_ex_write=1, all bubble/flush/start=0.
- States: RUN, MC_WAIT.
- RUN, priority high to low:
  1. ex_branch_taken: if_id_flush=1, id_ex_bubble=1, pc_write=1. Any load-use hazard that cycle is discarded because the ID instruction is squashed.
  2. id_ex_mc_op && !mc_started:
     - mc_start=1 for exactly this cycle.
     - pc_write=if_id_write=id_ex_write=0, ex_mem_bubble=1.
     - Next state MC_WAIT, timeout counter=0.
  3. Load-use, defined as id_ex_mem_read && id_ex_rd!=0 && ((if_id_rs1_used && rs1==id_ex_rd) || (if_id_rs2_used && rs2==id_ex_rd)):
     - pc_write=0, if_id_write=0, id_ex_bubble=1 for one cycle.
     - Combinational, no state change; the hazard clears the next cycle because the load has advanced.
  4. Otherwise all enables=1, no bubbles.
- MC_WAIT:
  - pc_write=if_id_write=id_ex_write=0, ex_mem_bubble=1. mc_start=0.
  - ex_branch_taken is ignored: EX holds the mc op, so it cannot be a branch.
  - On mc_done: next state RUN and mc_started=1. The following cycle releases the pipeline with all enables=1 and no bubble; the mc op advances into EX/MEM with its result.
  - mc_started clears on the first RUN cycle in which id_ex_mc_op advances, i.e. id_ex_write=1. This prevents re-start of the same op. Back-to-back mc ops therefore each get one start.
  - Timeout counter increments each MC_WAIT cycle. On reaching MC_TIMEOUT-1 without mc_done: mc_error<=1 (sticky until rst), next state RUN, mc_started=1. The pipeline releases with a garbage result, which is a debug-only path.
  - mc_done in the same cycle as the timeout: mc_done wins and mc_error is not set.
- mc_done in RUN is ignored.
- stall_count increments by 1 in every cycle with pc_write=0. It saturates at all-ones and does not wrap.
- rst during MC_WAIT: immediate return to RUN, no mc_start re-issued. The multicycle unit is reset by the same rst.
- Latency: hazard responses are same-cycle combinational, with no added pipeline delay.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - state enum {RUN, MC_WAIT}
  - REG_ADDR_W constant
  - x0 index constant
- One sub-module, load_use_detect: purely combinational compare of rs1/rs2 against id_ex_rd with the used/x0 qualifiers. The forwarding logic can reuse it.
- FSM, timeout counter and stall counter stay in the top module.

Test Plan:
1. Load-use: id_ex_mem_read=1, id_ex_rd=5, rs1=5 used -> one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1. Next cycle all enables=1. stall_count=1.
2. rd=x0 and rs2-not-used: id_ex_rd=0 with rs1=0 used; then id_ex_rd=7, rs2=7, rs2_used=0 -> no stall in either case.
3. Branch plus load-use in the same cycle: ex_branch_taken=1 -> if_id_flush=1, id_ex_bubble=1, pc_write=1. stall_count unchanged.
4. MUL with mc_done 10 cycles after start:
   - mc_start pulses once.
   - 10 cycles with all enables=0 and ex_mem_bubble=1, then release.
   - stall_count=11. mc_error=0.
5. Timeout with MC_TIMEOUT=8 and mc_done never asserted -> return to RUN after 8 MC_WAIT cycles, mc_error=1 and held until rst.
6. rst asserted on the 3rd MC_WAIT cycle -> next cycle state RUN, stall_count=0, mc_start stays 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall control logic.
package pipe_ctrl_pkg;

  // Sequencer states: normal flow, or frozen waiting on the MUL/DIV unit.
  typedef enum logic [0:0] {
    StRun    = 1'b0,
    StMcWait = 1'b1
  } hcu_state_e;

  localparam int unsigned RegAddrW = 5;
  // Register x0 is hardwired to zero, so it never creates a true dependency.
  localparam int unsigned RegX0    = 0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the ID and EX instructions.
module load_use_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = RegAddrW
) (
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  input  logic                  mem_read,
  input  logic [REG_ADDR_W-1:0] rd,
  output logic                  hazard
);

  logic rd_nonzero;
  logic rs1_match;
  logic rs2_match;

  // Flag an ID source that the in-flight load will write.
  always_comb begin
    rd_nonzero = (rd != REG_ADDR_W'(RegX0));
    rs1_match  = rs1_used && (rs1 == rd);
    rs2_match  = rs2_used && (rs2 == rd);
    hazard     = mem_read && rd_nonzero && (rs1_match || rs2_match);
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush sequencer: load-use bubbles, branch flushes, MUL/DIV handshake
// with timeout, and a saturating stall-cycle counter.
module hazard_control_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = RegAddrW,
  parameter int unsigned MC_TIMEOUT = 64,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] if_id_rs1,
  input  logic [REG_ADDR_W-1:0] if_id_rs2,
  input  logic                  if_id_rs1_used,
  input  logic                  if_id_rs2_used,
  input  logic                  id_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] id_ex_rd,
  input  logic                  id_ex_mc_op,
  input  logic                  ex_branch_taken,
  input  logic                  mc_done,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  id_ex_write,
  output logic                  id_ex_bubble,
  output logic                  if_id_flush,
  output logic                  ex_mem_bubble,
  output logic                  mc_start,
  output logic                  mc_error,
  output logic [CNT_W-1:0]      stall_count
);

  localparam int unsigned ToW = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [ToW-1:0] ToLast = ToW'(MC_TIMEOUT - 1);

  hcu_state_e     state_q;
  logic [ToW-1:0] to_cnt_q;
  logic           mc_started_q;
  logic           mc_error_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic           load_use;

  load_use_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_load_use_detect (
    .rs1      (if_id_rs1),
    .rs2      (if_id_rs2),
    .rs1_used (if_id_rs1_used),
    .rs2_used (if_id_rs2_used),
    .mem_read (id_ex_mem_read),
    .rd       (id_ex_rd),
    .hazard   (load_use)
  );

  // Same-cycle decode of enables, bubbles and start from state and hazards.
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    id_ex_bubble  = 1'b0;
    if_id_flush   = 1'b0;
    ex_mem_bubble = 1'b0;
    mc_start      = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StRun: begin
          if (ex_branch_taken) begin
            // The squashed ID instruction makes any load-use hazard moot.
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (id_ex_mc_op && !mc_started_q) begin
            mc_start      = 1'b1;
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_bubble = 1'b1;
          end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end
        StMcWait: begin
          // EX holds the mc op, so a taken branch cannot be present here.
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_write   = 1'b0;
          ex_mem_bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Sequencer state, MUL/DIV timeout and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StRun;
      to_cnt_q     <= '0;
      mc_started_q <= 1'b0;
      mc_error_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          // The started op has left EX once ID/EX is written again.
          if (id_ex_write) begin
            mc_started_q <= 1'b0;
          end
          if (mc_start) begin
            state_q  <= StMcWait;
            to_cnt_q <= '0;
          end
        end
        StMcWait: begin
          to_cnt_q <= to_cnt_q + 1'b1;
          if (mc_done) begin
            state_q      <= StRun;
            mc_started_q <= 1'b1;
          end else if (to_cnt_q == ToLast) begin
            // Debug-only escape: release with a garbage result.
            state_q      <= StRun;
            mc_started_q <= 1'b1;
            mc_error_q   <= 1'b1;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (!pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign mc_error    = mc_error_q;
  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit. A second instance with a short
// timeout and a narrow stall counter covers the timeout and saturation paths.
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] if_id_rs1, if_id_rs2, id_ex_rd;
  logic       if_id_rs1_used, if_id_rs2_used, id_ex_mem_read;
  logic       id_ex_mc_op, ex_branch_taken, mc_done;

  logic        pc_write, if_id_write, id_ex_write, id_ex_bubble;
  logic        if_id_flush, ex_mem_bubble, mc_start, mc_error;
  logic [15:0] stall_count;

  logic       b_pc_write, b_if_id_write, b_id_ex_write, b_id_ex_bubble;
  logic       b_if_id_flush, b_ex_mem_bubble, b_mc_start, b_mc_error;
  logic [3:0] b_stall_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_control_unit dut (
    .clk (clk), .rst (rst),
    .if_id_rs1 (if_id_rs1), .if_id_rs2 (if_id_rs2),
    .if_id_rs1_used (if_id_rs1_used), .if_id_rs2_used (if_id_rs2_used),
    .id_ex_mem_read (id_ex_mem_read), .id_ex_rd (id_ex_rd),
    .id_ex_mc_op (id_ex_mc_op), .ex_branch_taken (ex_branch_taken),
    .mc_done (mc_done),
    .pc_write (pc_write), .if_id_write (if_id_write), .id_ex_write (id_ex_write),
    .id_ex_bubble (id_ex_bubble), .if_id_flush (if_id_flush),
    .ex_mem_bubble (ex_mem_bubble), .mc_start (mc_start), .mc_error (mc_error),
    .stall_count (stall_count)
  );

  hazard_control_unit #(
    .MC_TIMEOUT (8),
    .CNT_W      (4)
  ) dut_b (
    .clk (clk), .rst (rst),
    .if_id_rs1 (if_id_rs1), .if_id_rs2 (if_id_rs2),
    .if_id_rs1_used (if_id_rs1_used), .if_id_rs2_used (if_id_rs2_used),
    .id_ex_mem_read (id_ex_mem_read), .id_ex_rd (id_ex_rd),
    .id_ex_mc_op (id_ex_mc_op), .ex_branch_taken (ex_branch_taken),
    .mc_done (mc_done),
    .pc_write (b_pc_write), .if_id_write (b_if_id_write),
    .id_ex_write (b_id_ex_write), .id_ex_bubble (b_id_ex_bubble),
    .if_id_flush (b_if_id_flush), .ex_mem_bubble (b_ex_mem_bubble),
    .mc_start (b_mc_start), .mc_error (b_mc_error), .stall_count (b_stall_count)
  );

  // Advance to just after the next rising edge; inputs change here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_id_rs1 = '0; if_id_rs2 = '0; id_ex_rd = '0;
    if_id_rs1_used = 1'b0; if_id_rs2_used = 1'b0; id_ex_mem_read = 1'b0;
    id_ex_mc_op = 1'b0; ex_branch_taken = 1'b0; mc_done = 1'b0;
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b1;
    clear_inputs();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    cyc();
    rst = 1'b1;
    id_ex_mc_op = 1'b1;
    id_ex_mem_read = 1'b1; id_ex_rd = 5'd5; if_id_rs1 = 5'd5; if_id_rs1_used = 1'b1;
    #2;
    checks++; if (pc_write !== 1'b1) begin errors++;
      $display("FAIL reset_pc_write: got %b want 1", pc_write); end
    checks++; if (mc_start !== 1'b0) begin errors++;
      $display("FAIL reset_mc_start: got %b want 0", mc_start); end
    checks++; if (id_ex_bubble !== 1'b0) begin errors++;
      $display("FAIL reset_bubble: got %b want 0", id_ex_bubble); end
    cyc();
    rst = 1'b0;
    clear_inputs();
    #2;
    checks++; if (stall_count !== 16'd0) begin errors++;
      $display("FAIL reset_stall_count: got %0d want 0", stall_count); end
    checks++; if (mc_error !== 1'b0) begin errors++;
      $display("FAIL reset_mc_error: got %b want 0", mc_error); end
    checks++; if ({pc_write, if_id_write, id_ex_write} !== 3'b111) begin errors++;
      $display("FAIL reset_enables: got %b want 111", {pc_write, if_id_write, id_ex_write}); end
  endtask

  task automatic test_load_use();
    cyc();
    id_ex_mem_read = 1'b1; id_ex_rd = 5'd5; if_id_rs1 = 5'd5; if_id_rs1_used = 1'b1;
    #2;
    checks++;
    if ({pc_write, if_id_write, id_ex_write, id_ex_bubble} !== 4'b0011) begin errors++;
      $display("FAIL load_use_stall: got %b want 0011",
               {pc_write, if_id_write, id_ex_write, id_ex_bubble}); end
    cyc();
    clear_inputs();
    #2;
    checks++;
    if ({pc_write, if_id_write, id_ex_write, id_ex_bubble} !== 4'b1110) begin errors++;
      $display("FAIL load_use_release: got %b want 1110",
               {pc_write, if_id_write, id_ex_write, id_ex_bubble}); end
    checks++; if (stall_count !== 16'd1) begin errors++;
      $display("FAIL load_use_count: got %0d want 1", stall_count); end
  endtask

  task automatic test_no_stall();
    cyc();
    id_ex_mem_read = 1'b1; id_ex_rd = 5'd0; if_id_rs1 = 5'd0; if_id_rs1_used = 1'b1;
    #2;
    checks++; if ({pc_write, id_ex_bubble} !== 2'b10) begin errors++;
      $display("FAIL x0_no_stall: got %b want 10", {pc_write, id_ex_bubble}); end
    cyc();
    id_ex_rd = 5'd7; if_id_rs1 = 5'd3; if_id_rs2 = 5'd7; if_id_rs2_used = 1'b0;
    #2;
    checks++; if ({pc_write, id_ex_bubble} !== 2'b10) begin errors++;
      $display("FAIL rs2_unused_no_stall: got %b want 10", {pc_write, id_ex_bubble}); end
    cyc();
    if_id_rs2_used = 1'b1;
    #2;
    checks++; if ({pc_write, id_ex_bubble} !== 2'b01) begin errors++;
      $display("FAIL rs2_used_stall: got %b want 01", {pc_write, id_ex_bubble}); end
    cyc();
    clear_inputs();
    #2;
    checks++; if (stall_count !== 16'd2) begin errors++;
      $display("FAIL no_stall_count: got %0d want 2", stall_count); end
  endtask

  task automatic test_branch();
    cyc();
    id_ex_mem_read = 1'b1; id_ex_rd = 5'd5; if_id_rs1 = 5'd5; if_id_rs1_used = 1'b1;
    ex_branch_taken = 1'b1;
    #2;
    checks++;
    if ({if_id_flush, id_ex_bubble, pc_write, if_id_write} !== 4'b1111) begin errors++;
      $display("FAIL branch_flush: got %b want 1111",
               {if_id_flush, id_ex_bubble, pc_write, if_id_write}); end
    cyc();
    clear_inputs();
    #2;
    checks++; if (if_id_flush !== 1'b0) begin errors++;
      $display("FAIL branch_flush_clear: got %b want 0", if_id_flush); end
    checks++; if (stall_count !== 16'd2) begin errors++;
      $display("FAIL branch_count: got %0d want 2", stall_count); end
  endtask

  task automatic test_mul();
    do_reset();
    cyc();
    id_ex_mc_op = 1'b1;
    #2;
    checks++;
    if ({mc_start, pc_write, id_ex_write, ex_mem_bubble} !== 4'b1001) begin errors++;
      $display("FAIL mul_start: got %b want 1001",
               {mc_start, pc_write, id_ex_write, ex_mem_bubble}); end
    for (int i = 1; i <= 10; i++) begin
      cyc();
      mc_done = (i == 10);
      #2;
      checks++;
      if ({mc_start, pc_write, if_id_write, id_ex_write, ex_mem_bubble} !== 5'b00001)
      begin errors++;
        $display("FAIL mul_wait%0d: got %b want 00001", i,
                 {mc_start, pc_write, if_id_write, id_ex_write, ex_mem_bubble}); end
    end
    cyc();
    mc_done = 1'b0;
    #2;
    checks++;
    if ({mc_start, pc_write, if_id_write, id_ex_write, ex_mem_bubble} !== 5'b01110)
    begin errors++;
      $display("FAIL mul_release: got %b want 01110",
               {mc_start, pc_write, if_id_write, id_ex_write, ex_mem_bubble}); end
    checks++; if (stall_count !== 16'd11) begin errors++;
      $display("FAIL mul_count: got %0d want 11", stall_count); end
    checks++; if (mc_error !== 1'b0) begin errors++;
      $display("FAIL mul_error: got %b want 0", mc_error); end
  endtask

  task automatic test_back_to_back();
    // A second mc op directly follows the released one.
    cyc();
    #2;
    checks++; if (mc_start !== 1'b1) begin errors++;
      $display("FAIL b2b_start: got %b want 1", mc_start); end
    cyc();
    mc_done = 1'b1;
    #2;
    checks++; if ({mc_start, pc_write} !== 2'b00) begin errors++;
      $display("FAIL b2b_wait: got %b want 00", {mc_start, pc_write}); end
    cyc();
    mc_done = 1'b0;
    #2;
    checks++; if ({mc_start, pc_write} !== 2'b01) begin errors++;
      $display("FAIL b2b_release: got %b want 01", {mc_start, pc_write}); end
    checks++; if (stall_count !== 16'd13) begin errors++;
      $display("FAIL b2b_count: got %0d want 13", stall_count); end
    id_ex_mc_op = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    cyc();
    id_ex_mc_op = 1'b1;
    #2;
    checks++; if (b_mc_start !== 1'b1) begin errors++;
      $display("FAIL to_start: got %b want 1", b_mc_start); end
    for (int i = 1; i <= 8; i++) begin
      cyc();
      #2;
      checks++; if ({b_pc_write, b_mc_error} !== 2'b00) begin errors++;
        $display("FAIL to_wait%0d: got %b want 00", i, {b_pc_write, b_mc_error}); end
    end
    cyc();
    #2;
    checks++; if ({b_pc_write, b_mc_start, b_mc_error} !== 3'b101) begin errors++;
      $display("FAIL to_release: got %b want 101", {b_pc_write, b_mc_start, b_mc_error}); end
    checks++; if ({pc_write, mc_error} !== 2'b00) begin errors++;
      $display("FAIL to_long_instance: got %b want 00", {pc_write, mc_error}); end
    cyc();
    id_ex_mc_op = 1'b0;
    repeat (3) cyc();
    #2;
    checks++; if (b_mc_error !== 1'b1) begin errors++;
      $display("FAIL to_sticky: got %b want 1", b_mc_error); end
    do_reset();
    #2;
    checks++; if (b_mc_error !== 1'b0) begin errors++;
      $display("FAIL to_cleared: got %b want 0", b_mc_error); end
  endtask

  task automatic test_done_at_timeout();
    do_reset();
    cyc();
    id_ex_mc_op = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      mc_done = (i == 8);
    end
    cyc();
    mc_done = 1'b0;
    id_ex_mc_op = 1'b0;
    #2;
    checks++; if ({b_pc_write, b_mc_error} !== 2'b10) begin errors++;
      $display("FAIL done_at_timeout: got %b want 10", {b_pc_write, b_mc_error}); end
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    cyc();
    id_ex_mc_op = 1'b1;
    cyc();
    cyc();
    cyc();
    rst = 1'b1;
    #2;
    checks++; if ({pc_write, mc_start, ex_mem_bubble} !== 3'b100) begin errors++;
      $display("FAIL rst_wait_forced: got %b want 100", {pc_write, mc_start, ex_mem_bubble}); end
    cyc();
    rst = 1'b0;
    id_ex_mc_op = 1'b0;
    #2;
    checks++; if ({pc_write, mc_start, ex_mem_bubble} !== 3'b100) begin errors++;
      $display("FAIL rst_wait_run: got %b want 100", {pc_write, mc_start, ex_mem_bubble}); end
    checks++; if (stall_count !== 16'd0) begin errors++;
      $display("FAIL rst_wait_count: got %0d want 0", stall_count); end
  endtask

  task automatic test_stall_saturate();
    do_reset();
    cyc();
    id_ex_mem_read = 1'b1; id_ex_rd = 5'd9; if_id_rs2 = 5'd9; if_id_rs2_used = 1'b1;
    repeat (19) cyc();
    cyc();
    clear_inputs();
    #2;
    checks++; if (stall_count !== 16'd20) begin errors++;
      $display("FAIL sat_wide_count: got %0d want 20", stall_count); end
    checks++; if (b_stall_count !== 4'd15) begin errors++;
      $display("FAIL sat_narrow_count: got %0d want 15", b_stall_count); end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch();
    test_mul();
    test_back_to_back();
    test_timeout();
    test_done_at_timeout();
    test_reset_in_wait();
    test_stall_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
